// File: rtl/pll_lock_supervisor_pkg.sv
// pll_lock_supervisor_pkg: state encodings and sizing helper shared by the PLL supervisor
package pll_lock_supervisor_pkg;
  typedef enum logic [2:0] {
    ST_PLLRST = 3'd0,
    ST_WAIT   = 3'd1,
    ST_FILTER = 3'd2,
    ST_HOLD   = 3'd3,
    ST_RUN    = 3'd4
  } pll_st_e;
  function automatic int max4(input int a, input int b, input int c, input int d);
    int m;
    m = a > b ? a : b;
    m = m > c ? m : c;
    return m > d ? m : d;
  endfunction
endpackage

// File: rtl/pll_lock_supervisor_sync_ff.sv
// sync_ff: generic multi-flop bit synchronizer with synchronous active-low reset
module sync_ff #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic resetn,
  input  logic d,
  output logic q
);
  logic [STAGES-1:0] r;
  always_ff @(posedge clk)
    if (!resetn) r <= '0;
    else r <= {r[STAGES-2:0], d};
  assign q = r[STAGES-1];
endmodule

// File: rtl/pll_lock_supervisor.sv
// pll_lock_supervisor: drives PLL reset, filters lock, releases system reset and counts events
module pll_lock_supervisor
  import pll_lock_supervisor_pkg::*;
#(
  parameter int SYNC_STAGES    = 2,
  parameter int PLL_RST_CYCLES = 64,
  parameter int LOCK_TIMEOUT   = 50000,
  parameter int LOCK_FILTER    = 1024,
  parameter int RST_HOLD       = 256,
  parameter int CNT_W          = 8
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             pll_lock_i,
  input  logic             force_relock_i,
  output logic             pll_reset_o,
  output logic             sys_resetn_o,
  output logic             locked_o,
  output logic [2:0]       state_o,
  output logic [CNT_W-1:0] loss_cnt_o,
  output logic [CNT_W-1:0] tmo_cnt_o
);
  localparam int TW = $clog2(max4(PLL_RST_CYCLES, LOCK_TIMEOUT, LOCK_FILTER, RST_HOLD) + 1);
  logic lk, done, loss_inc, tmo_inc;
  logic [TW-1:0] tmr, lim;
  pll_st_e st, nxt;
  sync_ff #(.STAGES(SYNC_STAGES)) u_sync (
    .clk(clk), .resetn(resetn), .d(pll_lock_i), .q(lk)
  );
  always_comb begin
    lim = st == ST_PLLRST ? TW'(PLL_RST_CYCLES - 1) :
          st == ST_WAIT   ? TW'(LOCK_TIMEOUT - 1)   :
          st == ST_FILTER ? TW'(LOCK_FILTER - 1)    : TW'(RST_HOLD - 1);
    done = tmr == lim;
  end
  always_comb begin
    nxt = st;
    loss_inc = 1'b0;
    tmo_inc = 1'b0;
    unique case (st)
      ST_PLLRST: nxt = done ? ST_WAIT : ST_PLLRST;
      ST_WAIT: begin
        tmo_inc = !lk && done;
        nxt = (tmo_inc || force_relock_i) ? ST_PLLRST : lk ? ST_FILTER : ST_WAIT;
      end
      ST_FILTER: nxt = !lk ? ST_WAIT : force_relock_i ? ST_PLLRST : done ? ST_HOLD : ST_FILTER;
      ST_HOLD: nxt = (!lk || force_relock_i) ? ST_PLLRST : done ? ST_RUN : ST_HOLD;
      ST_RUN: begin
        loss_inc = !lk;
        nxt = (!lk || force_relock_i) ? ST_PLLRST : ST_RUN;
      end
      default: nxt = ST_PLLRST;
    endcase
  end
  always_ff @(posedge clk)
    if (!resetn) begin
      st <= ST_PLLRST;
      tmr <= '0;
      pll_reset_o <= 1'b1;
      sys_resetn_o <= 1'b0;
      locked_o <= 1'b0;
      loss_cnt_o <= '0;
      tmo_cnt_o <= '0;
    end else begin
      st <= nxt;
      tmr <= (nxt != st || st == ST_RUN) ? '0 : tmr + 1'b1;
      pll_reset_o <= nxt == ST_PLLRST;
      sys_resetn_o <= nxt == ST_RUN;
      locked_o <= nxt == ST_RUN;
      loss_cnt_o <= loss_cnt_o + CNT_W'(loss_inc && !(&loss_cnt_o));
      tmo_cnt_o <= tmo_cnt_o + CNT_W'(tmo_inc && !(&tmo_cnt_o));
    end
  assign state_o = st;
endmodule

// File: tb/tb_pll_lock_supervisor.sv
// tb_pll_lock_supervisor: table-driven cycle checks plus a loss-counter saturation sequence
module tb_pll_lock_supervisor;
  typedef struct {
    int n;
    bit rn, lk, fr;
    bit [2:0] st;
    bit pr, sr, ld;
    bit [7:0] lc, tc;
  } vec_t;
  logic clk = 1'b0;
  logic resetn, pll_lock_i, force_relock_i;
  logic pll_reset_o, sys_resetn_o, locked_o;
  logic [2:0] state_o;
  logic [7:0] loss_cnt_o, tmo_cnt_o;
  int nvec = 0;
  int nfail = 0;
  vec_t tbl[$];
  always #5 clk = ~clk;
  pll_lock_supervisor #(
    .SYNC_STAGES(2), .PLL_RST_CYCLES(4), .LOCK_TIMEOUT(100),
    .LOCK_FILTER(8), .RST_HOLD(16), .CNT_W(8)
  ) dut (
    .clk(clk), .resetn(resetn), .pll_lock_i(pll_lock_i), .force_relock_i(force_relock_i),
    .pll_reset_o(pll_reset_o), .sys_resetn_o(sys_resetn_o), .locked_o(locked_o),
    .state_o(state_o), .loss_cnt_o(loss_cnt_o), .tmo_cnt_o(tmo_cnt_o)
  );
  function automatic vec_t mk(int n, bit rn, bit lk, bit fr, bit [2:0] st, bit pr, bit sr,
                              bit ld, bit [7:0] lc, bit [7:0] tc);
    vec_t v;
    v.n = n; v.rn = rn; v.lk = lk; v.fr = fr; v.st = st;
    v.pr = pr; v.sr = sr; v.ld = ld; v.lc = lc; v.tc = tc;
    return v;
  endfunction
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic check(input string nm, input int idx, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nfail++;
      $display("FAIL %s[%0d] got %h expected %h", nm, idx, got, exp);
    end
  endtask
  initial begin
    logic [21:0] got, exp;
    int w;
    resetn = 1'b0; pll_lock_i = 1'b0; force_relock_i = 1'b0;
    // fields: cycles, resetn, lock, force | state, pll_reset, sys_resetn, locked, loss, tmo
    tbl.push_back(mk(2,   0,0,0, 0,1,0,0, 0,0));
    tbl.push_back(mk(3,   1,0,0, 0,1,0,0, 0,0));
    tbl.push_back(mk(1,   1,0,0, 1,0,0,0, 0,0));
    tbl.push_back(mk(6,   1,0,0, 1,0,0,0, 0,0));
    tbl.push_back(mk(2,   1,1,0, 1,0,0,0, 0,0));
    tbl.push_back(mk(1,   1,1,0, 2,0,0,0, 0,0));
    tbl.push_back(mk(7,   1,1,0, 2,0,0,0, 0,0));
    tbl.push_back(mk(1,   1,1,0, 3,0,0,0, 0,0));
    tbl.push_back(mk(15,  1,1,0, 3,0,0,0, 0,0));
    tbl.push_back(mk(1,   1,1,0, 4,0,1,1, 0,0));
    tbl.push_back(mk(1,   1,0,0, 4,0,1,1, 0,0));
    tbl.push_back(mk(1,   1,1,0, 4,0,1,1, 0,0));
    tbl.push_back(mk(1,   1,1,0, 0,1,0,0, 1,0));
    tbl.push_back(mk(3,   1,1,0, 0,1,0,0, 1,0));
    tbl.push_back(mk(1,   1,1,0, 1,0,0,0, 1,0));
    tbl.push_back(mk(1,   1,1,0, 2,0,0,0, 1,0));
    tbl.push_back(mk(8,   1,1,0, 3,0,0,0, 1,0));
    tbl.push_back(mk(15,  1,1,0, 3,0,0,0, 1,0));
    tbl.push_back(mk(1,   1,1,0, 4,0,1,1, 1,0));
    tbl.push_back(mk(1,   1,1,1, 0,1,0,0, 1,0));
    tbl.push_back(mk(4,   1,1,0, 1,0,0,0, 1,0));
    tbl.push_back(mk(1,   1,1,0, 2,0,0,0, 1,0));
    tbl.push_back(mk(24,  1,1,0, 4,0,1,1, 1,0));
    tbl.push_back(mk(1,   1,1,1, 0,1,0,0, 1,0));
    tbl.push_back(mk(1,   1,1,1, 0,1,0,0, 1,0));
    tbl.push_back(mk(2,   1,1,0, 0,1,0,0, 1,0));
    tbl.push_back(mk(1,   1,1,0, 1,0,0,0, 1,0));
    tbl.push_back(mk(1,   1,1,0, 2,0,0,0, 1,0));
    tbl.push_back(mk(24,  1,1,0, 4,0,1,1, 1,0));
    tbl.push_back(mk(2,   1,0,0, 4,0,1,1, 1,0));
    tbl.push_back(mk(1,   1,0,1, 0,1,0,0, 2,0));
    tbl.push_back(mk(4,   1,0,0, 1,0,0,0, 2,0));
    tbl.push_back(mk(99,  1,0,0, 1,0,0,0, 2,0));
    tbl.push_back(mk(1,   1,0,0, 0,1,0,0, 2,1));
    tbl.push_back(mk(104, 1,0,0, 0,1,0,0, 2,2));
    tbl.push_back(mk(104, 1,0,0, 0,1,0,0, 2,3));
    tbl.push_back(mk(103, 1,0,0, 1,0,0,0, 2,3));
    tbl.push_back(mk(1,   1,0,1, 0,1,0,0, 2,4));
    tbl.push_back(mk(4,   1,0,0, 1,0,0,0, 2,4));
    tbl.push_back(mk(3,   1,1,0, 2,0,0,0, 2,4));
    tbl.push_back(mk(1,   1,0,0, 2,0,0,0, 2,4));
    tbl.push_back(mk(1,   1,1,0, 2,0,0,0, 2,4));
    tbl.push_back(mk(1,   1,1,0, 1,0,0,0, 2,4));
    tbl.push_back(mk(1,   1,1,0, 2,0,0,0, 2,4));
    tbl.push_back(mk(7,   1,1,0, 2,0,0,0, 2,4));
    tbl.push_back(mk(1,   1,1,0, 3,0,0,0, 2,4));
    tbl.push_back(mk(1,   0,1,0, 0,1,0,0, 0,0));
    foreach (tbl[i]) begin
      resetn = tbl[i].rn; pll_lock_i = tbl[i].lk; force_relock_i = tbl[i].fr;
      repeat (tbl[i].n) step();
      got = {state_o, pll_reset_o, sys_resetn_o, locked_o, loss_cnt_o, tmo_cnt_o};
      exp = {tbl[i].st, tbl[i].pr, tbl[i].sr, tbl[i].ld, tbl[i].lc, tbl[i].tc};
      check("vec", i, 32'(got), 32'(exp));
    end
    resetn = 1'b1; pll_lock_i = 1'b1; force_relock_i = 1'b0;
    for (int i = 0; i < 256; i++) begin
      w = 0;
      while (locked_o !== 1'b1 && w < 100) begin
        step();
        w++;
      end
      if (locked_o !== 1'b1) begin
        check("relock_timeout", i, 32'(locked_o), 32'd1);
        break;
      end
      pll_lock_i = 1'b0;
      step();
      pll_lock_i = 1'b1;
      step();
      step();
      check("loss_sat", i, 32'(loss_cnt_o), (i + 1 > 255) ? 32'd255 : 32'(i + 1));
    end
    check("sat_state", 0, 32'({state_o, sys_resetn_o, tmo_cnt_o}), 32'({3'd0, 1'b0, 8'd0}));
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end
endmodule
